// File: rtl/slt_unit_seq.sv
// slt_unit_seq: multi-cycle set-less-than unit for the ALU result mux.
// Computes A - B as A + ~B + 1, CHUNK bits per cycle, then derives the
// signed or unsigned less-than and an equality flag from the full difference.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. The input side is ready only in IDLE. The
// output side holds out_valid and f/lt/eq stable in DONE until out_ready.
// A new operation can be accepted no earlier than the edge after the result
// is taken, so operations never overlap.
module slt_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             lt,
    output logic             eq,
    output logic [1:0]       fsm_state
);

    // WIDTH must be an exact multiple of CHUNK; N chunks per operation.
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operand latches shift right by CHUNK each RUN cycle, so the chunk
    // being processed always sits in the low bits. On the last chunk the
    // low chunk holds the operand MSBs.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic             mode_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             zero_acc;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] nb_chunk;
    logic [CHUNK:0]   sum;
    logic [CHUNK-1:0] d;
    logic             carry_out;
    logic             last;
    logic             zero_next;
    logic             a_msb;
    logic             b_msb;
    logic             diff_msb;
    logic             ovf;
    logic             lt_next;

    assign fsm_state = state;

    // Chunk adder and result derivation; only meaningful in RUN.
    always_comb begin
        a_chunk   = a_q[CHUNK-1:0];
        nb_chunk  = nb_q[CHUNK-1:0];
        sum       = {1'b0, a_chunk} + {1'b0, nb_chunk} + {{CHUNK{1'b0}}, carry};
        d         = sum[CHUNK-1:0];
        carry_out = sum[CHUNK];
        last      = (cnt == LAST);
        zero_next = zero_acc & (d == '0);
        a_msb     = a_chunk[CHUNK-1];
        b_msb     = ~nb_chunk[CHUNK-1];
        diff_msb  = d[CHUNK-1];
        // Signed overflow: operands differ in sign and the difference
        // disagrees with A's sign, so the raw sign bit is inverted.
        ovf       = (a_msb != b_msb) & (diff_msb != a_msb);
        lt_next   = (mode_q ? (diff_msb ^ ovf) : ~carry_out) & ~zero_next;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered handshake flags, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // Datapath: operand capture, chunk-serial subtract, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            nb_q     <= '0;
            mode_q   <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            zero_acc <= 1'b0;
            f        <= '0;
            lt       <= 1'b0;
            eq       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        nb_q     <= ~b;
                        mode_q   <= signed_mode;
                        carry    <= 1'b1;
                        cnt      <= '0;
                        zero_acc <= 1'b1;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> CHUNK;
                    nb_q     <= nb_q >> CHUNK;
                    carry    <= carry_out;
                    zero_acc <= zero_next;
                    cnt      <= cnt + CW'(1);
                    if (last) begin
                        lt <= lt_next;
                        eq <= zero_next;
                        f  <= WIDTH'(lt_next);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slt_unit_seq.sv
// Bench for slt_unit_seq: three instances (32/8, 16/4, 32/32) share the
// clock, reset and operand buses; sel picks which one is being exercised.
module tb_slt_unit_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        mode;
        logic        exp_lt;
        logic        exp_eq;
        int          sel;
    } vec_t;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic mode_in;
    int sel;

    logic ir0, ir1, ir2, ov0, ov1, ov2, lt0, lt1, lt2, eq0, eq1, eq2;
    logic [31:0] f0, f2;
    logic [15:0] f1;
    logic [1:0] st0, st1, st2;

    logic cur_in_ready, cur_out_valid, cur_lt, cur_eq;
    logic [31:0] cur_f;
    logic [1:0] cur_st;

    int n_checks;
    int n_fail;
    logic [33:0] exp_q[$];

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    slt_unit_seq #(.WIDTH(32), .CHUNK(8)) dut_32_8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir0),
        .a(a_in), .b(b_in), .signed_mode(mode_in), .out_valid(ov0),
        .out_ready(out_ready && sel == 0), .f(f0), .lt(lt0), .eq(eq0), .fsm_state(st0));

    slt_unit_seq #(.WIDTH(16), .CHUNK(4)) dut_16_4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir1),
        .a(a_in[15:0]), .b(b_in[15:0]), .signed_mode(mode_in), .out_valid(ov1),
        .out_ready(out_ready && sel == 1), .f(f1), .lt(lt1), .eq(eq1), .fsm_state(st1));

    slt_unit_seq #(.WIDTH(32), .CHUNK(32)) dut_32_32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir2),
        .a(a_in), .b(b_in), .signed_mode(mode_in), .out_valid(ov2),
        .out_ready(out_ready && sel == 2), .f(f2), .lt(lt2), .eq(eq2), .fsm_state(st2));

    always_comb begin
        cur_in_ready  = ir0;
        cur_out_valid = ov0;
        cur_lt        = lt0;
        cur_eq        = eq0;
        cur_f         = f0;
        cur_st        = st0;
        if (sel == 1) begin
            cur_in_ready  = ir1;
            cur_out_valid = ov1;
            cur_lt        = lt1;
            cur_eq        = eq1;
            cur_f         = {16'h0, f1};
            cur_st        = st1;
        end else if (sel == 2) begin
            cur_in_ready  = ir2;
            cur_out_valid = ov2;
            cur_lt        = lt2;
            cur_eq        = eq2;
            cur_f         = f2;
            cur_st        = st2;
        end
    end

    function automatic int latency(int s);
        return (s == 2) ? 1 : 4;
    endfunction

    // Reference compare: returns {eq, lt} for the instance's width.
    function automatic logic [1:0] model(logic [31:0] x, logic [31:0] y, logic m, int s);
        logic l, e;
        logic [15:0] xs, ys;
        xs = x[15:0];
        ys = y[15:0];
        if (s == 1) begin
            e = (xs == ys);
            l = m ? ($signed(xs) < $signed(ys)) : (xs < ys);
        end else begin
            e = (x == y);
            l = m ? ($signed(x) < $signed(y)) : (x < y);
        end
        return {e, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (sel %0d, t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (sel %0d, t=%0t)", name, sel, $time);
    endtask

    // Single operation with optional back-pressure of 'hold' cycles.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tm,
                          input logic e_lt, input logic e_eq, input int hold, input string name);
        int k;
        logic [33:0] e;
        k = 0;
        @(negedge clk);
        while (!cur_in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cur_in_ready) begin
            fail_now({name, " in_ready"});
            return;
        end
        a_in = ta;
        b_in = tb;
        mode_in = tm;
        in_valid = 1'b1;
        exp_q.push_back({e_eq, e_lt, 32'(e_lt)});
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cur_out_valid && k < 50);
        if (!cur_out_valid) begin
            fail_now({name, " out_valid"});
            exp_q.delete();
            return;
        end
        chk({name, " latency"}, 32'(k - 1), 32'(latency(sel)));
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            chk({name, " hold out_valid"}, 32'(cur_out_valid), 32'd1);
            chk({name, " hold f"}, cur_f, e[31:0]);
            chk({name, " hold eq"}, 32'(cur_eq), 32'(e[33]));
            @(negedge clk);
        end
        chk({name, " f"}, cur_f, e[31:0]);
        chk({name, " lt"}, 32'(cur_lt), 32'(e[32]));
        chk({name, " eq"}, 32'(cur_eq), 32'(e[33]));
        chk({name, " no in_ready in DONE"}, 32'(cur_in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({name, " out_valid drop"}, 32'(cur_out_valid), 32'd0);
        chk({name, " in_ready rise"}, 32'(cur_in_ready), 32'd1);
    endtask

    // Back-to-back random operations with in_valid held high.
    task automatic b2b(input int s, input int count);
        logic [31:0] ra[8];
        logic [31:0] rb[8];
        logic rm[8];
        logic [33:0] e;
        logic [1:0] m;
        logic acc;
        int idx, got, cyc;
        sel = s;
        for (int i = 0; i < count; i++) begin
            ra[i] = $urandom();
            rb[i] = (i == 2) ? ra[i] : $urandom();
            if (i == 3) rb[i] = ra[i] ^ 32'h8000_8000;
            rm[i] = 1'(i % 2);
        end
        idx = 0;
        got = 0;
        cyc = 0;
        out_ready = 1'b1;
        @(negedge clk);
        a_in = ra[0];
        b_in = rb[0];
        mode_in = rm[0];
        in_valid = 1'b1;
        while (got < count && cyc < 200) begin
            if (cur_in_ready && cur_out_valid) fail_now("b2b overlap");
            acc = cur_in_ready && in_valid;
            if (acc) begin
                m = model(a_in, b_in, mode_in, s);
                exp_q.push_back({m[1], m[0], 32'(m[0])});
            end
            if (cur_out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("b2b unexpected result");
                end else begin
                    e = exp_q.pop_front();
                    chk("b2b f", cur_f, e[31:0]);
                    chk("b2b lt", 32'(cur_lt), 32'(e[32]));
                    chk("b2b eq", 32'(cur_eq), 32'(e[33]));
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < count) begin
                    a_in = ra[idx];
                    b_in = rb[idx];
                    mode_in = rm[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (got < count) fail_now("b2b results");
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b accepted", 32'(idx), 32'(count));
        chk("b2b queue drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Main sequence and final report.
    initial begin
        vec_t vecs[16];
        bit seen_valid;
        n_checks = 0;
        n_fail = 0;
        sel = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        mode_in = 1'b0;

        vecs[0]  = '{32'd5,         32'd9,         1'b0, 1'b1, 1'b0, 0};
        vecs[1]  = '{32'd9,         32'd5,         1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{32'hFFFFFFFF,  32'd1,         1'b1, 1'b1, 1'b0, 0};
        vecs[3]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{32'h80000000,  32'h7FFFFFFF,  1'b1, 1'b1, 1'b0, 0};
        vecs[5]  = '{32'h7FFFFFFF,  32'h80000000,  1'b1, 1'b0, 1'b0, 0};
        vecs[6]  = '{32'h80000000,  32'h7FFFFFFF,  1'b0, 1'b0, 1'b0, 0};
        vecs[7]  = '{32'd5,         32'd5,         1'b1, 1'b0, 1'b1, 0};
        vecs[8]  = '{32'd1,         32'hFFFFFFFF,  1'b1, 1'b0, 1'b0, 0};
        vecs[9]  = '{32'h00008000,  32'h00007FFF,  1'b1, 1'b1, 1'b0, 1};
        vecs[10] = '{32'h0000FFFF,  32'd1,         1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{32'h00001234,  32'h00001235,  1'b0, 1'b1, 1'b0, 1};
        vecs[12] = '{32'h0000ABCD,  32'h0000ABCD,  1'b0, 1'b0, 1'b1, 1};
        vecs[13] = '{32'hFFFFFFFF,  32'd1,         1'b1, 1'b1, 1'b0, 2};
        vecs[14] = '{32'h80000000,  32'h7FFFFFFF,  1'b1, 1'b1, 1'b0, 2};
        vecs[15] = '{32'd3,         32'd3,         1'b0, 1'b0, 1'b1, 2};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state on every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset in_ready", 32'(cur_in_ready), 32'd1);
            chk("reset out_valid", 32'(cur_out_valid), 32'd0);
            chk("reset f", cur_f, 32'd0);
            chk("reset lt", 32'(cur_lt), 32'd0);
            chk("reset eq", 32'(cur_eq), 32'd0);
            chk("reset state", 32'(cur_st), 32'd0);
        end

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            sel = vecs[i].sel;
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp_lt, vecs[i].exp_eq, 0,
                   $sformatf("vec%0d", i));
        end

        // Equality with back-pressure held for 6 cycles.
        sel = 0;
        run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 6, "backpressure");

        // Reset in the middle of RUN, after a result left f=1.
        run_op(32'd5, 32'd9, 1'b0, 1'b1, 1'b0, 0, "pre_reset");
        @(negedge clk);
        a_in = 32'd5;
        b_in = 32'd9;
        mode_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun reset in_ready", 32'(cur_in_ready), 32'd1);
        chk("midrun reset f", cur_f, 32'd0);
        chk("midrun reset out_valid", 32'(cur_out_valid), 32'd0);
        chk("midrun reset state", 32'(cur_st), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cur_out_valid) seen_valid = 1'b1;
        end
        chk("midrun reset no result", 32'(seen_valid), 32'd0);

        // Back-to-back random pairs on each configuration.
        b2b(0, 4);
        b2b(1, 4);
        b2b(2, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slt_unit_seq.md
Name: slt_unit_seq

Overview:
- Parametrised, multi-cycle set-less-than unit for the ALU result mux. Successor to the single-cycle 32-bit SLT.
- Evaluates A - B chunk-serially as A + ~B + 1, CHUNK bits per cycle. Supports signed (SLT) and unsigned (SLTU) modes.
- Signed mode is overflow-correct: it does not use the raw sign bit of the difference.
- Returns a zero-extended 0/1 result and an equality flag through valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width. Must be an exact multiple of CHUNK.
- CHUNK, 8, bits of the difference processed per cycle. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  unit can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  1 = signed compare (SLT), 0 = unsigned (SLTU).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- f  output  WIDTH  {WIDTH-1 zeros, lt}.
- lt  output  1  A < B under the selected mode.
- eq  output  1  A == B.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; f=0; lt=0; eq=0.
  - Internal registers cleared: carry, cnt, zero_acc, operand latches.
  - Reset mid-operation discards the operation; no out_valid follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch a, ~b, signed_mode; carry=1, cnt=0, zero_acc=1 -> RUN.
  - Inputs are ignored whenever in_ready=0.
- RUN:
  - in_ready=0.
  - Each cycle: {carry, d} = a[cnt*CHUNK +: CHUNK] + nb[cnt*CHUNK +: CHUNK] + carry.
  - zero_acc &= (d == 0). Capture the MSB of d on the last chunk. cnt++.
  - On cnt == N-1, compute the result, register f/lt/eq -> DONE.
- Result rules, using the final carry_out, diff_msb, a_msb and b_msb:
  - Unsigned: lt = ~carry_out.
  - Signed: ovf = (a_msb != b_msb) & (diff_msb != a_msb); lt = diff_msb ^ ovf.
  - eq = zero_acc including the last chunk; eq=1 forces lt=0.
  - f = lt zero-extended to WIDTH.
- Latency: operation accepted at edge E0; out_valid is high after edge E0+N (N=4 for 32/8).
- DONE:
  - out_valid=1; f, lt and eq are held stable until out_ready=1 at a rising edge.
  - On that edge -> IDLE; out_valid drops and in_ready rises the same edge.
  - A new operation is accepted no earlier than the following edge; there is no overlap.
- Outputs after handshake: f/lt/eq retain their last value but are meaningful only while out_valid=1.
- Back-pressure: out_ready low holds DONE indefinitely; no result is lost or overwritten.
- Degenerate CHUNK=WIDTH: N=1, single RUN cycle, same handshake.
- Every register uses the async-reset always block. No latches; all outputs are registered.

Test Plan:
- Reset mid-RUN: a=5, b=9 accepted, rst_n pulsed low on cycle 2 -> out_valid never asserts; in_ready=1, f=0 immediately on reset.
- Unsigned basic, WIDTH=32/CHUNK=8: a=5, b=9, signed_mode=0 -> out_valid after exactly 4 cycles, f=32'h1, lt=1, eq=0. Swap operands -> f=0, lt=0.
- Signed vs unsigned: a=32'hFFFFFFFF, b=1 -> signed f=1 (-1<1); unsigned f=0.
- Overflow corner, signed: a=32'h80000000, b=32'h7FFFFFFF -> lt=1 (raw diff MSB is 0; ovf corrects it). a=32'h7FFFFFFF, b=32'h80000000 -> lt=0.
- Equality and back-pressure: a=b=32'hDEADBEEF, out_ready held low 6 cycles -> out_valid stays 1, eq=1, lt=0, f=0 stable. out_ready=1 -> IDLE next edge, in_ready=1.
- Back-to-back with in_valid held high and 4 random operand pairs -> each accepted only in IDLE; results match a reference model in both modes. Repeat with WIDTH=16, CHUNK=4 and WIDTH=32, CHUNK=32 (1-cycle latency).
